// File: rtl/vc_arbiter.sv
// Weighted two-VC arbiter popping VC0/VC1 FIFOs with downstream pause.
// Define VC_ARB_STATS_EN to add saturating per-VC grant counters.
module vc_arbiter #(
  parameter int unsigned VC0_WEIGHT = 4,
  parameter int unsigned VC1_WEIGHT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        VC0_empty,
  input  logic        VC1_empty,
  input  logic        pause,
`ifdef VC_ARB_STATS_EN
  input  logic        stats_clr,
  output logic [15:0] vc0_grant_cnt,
  output logic [15:0] vc1_grant_cnt,
`endif
  output logic        VC0_pop,
  output logic        VC1_pop,
  output logic        vc0_delay,
  output logic        arb_idle
);

  typedef enum logic [1:0] {
    IDLE,
    SERVE_VC0,
    SERVE_VC1,
    PAUSE
  } state_t;

  // A zero weight would starve a VC forever, so it is clamped to 1.
  localparam logic [3:0] W0_RAW = VC0_WEIGHT[3:0];
  localparam logic [3:0] W1_RAW = VC1_WEIGHT[3:0];
  localparam logic [3:0] W0 = (W0_RAW == 4'd0) ? 4'd1 : W0_RAW;
  localparam logic [3:0] W1 = (W1_RAW == 4'd0) ? 4'd1 : W1_RAW;

  state_t     state, state_n;
  state_t     saved, saved_n;
  logic [3:0] credit, credit_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      saved  <= SERVE_VC0;
      credit <= 4'd0;
    end else begin
      state  <= state_n;
      saved  <= saved_n;
      credit <= credit_n;
    end
  end

  assign VC0_pop  = (state == SERVE_VC0) & ~VC0_empty & ~pause;
  assign VC1_pop  = (state == SERVE_VC1) & ~VC1_empty & ~pause;
  assign arb_idle = (state == IDLE);

  always_comb begin
    state_n  = state;
    saved_n  = saved;
    credit_n = credit;
    unique case (state)
      IDLE: begin
        if (!pause) begin
          if (!VC0_empty) begin
            state_n  = SERVE_VC0;
            credit_n = W0;
          end else if (!VC1_empty) begin
            state_n  = SERVE_VC1;
            credit_n = W1;
          end
        end
      end
      SERVE_VC0: begin
        if (pause) begin
          state_n = PAUSE;
          saved_n = SERVE_VC0;
        end else if (!VC0_empty) begin
          if (credit > 4'd1) begin
            credit_n = credit - 4'd1;
          end else if (!VC1_empty) begin
            state_n  = SERVE_VC1;
            credit_n = W1;
          end else begin
            credit_n = W0;
          end
        end else if (!VC1_empty) begin
          state_n  = SERVE_VC1;
          credit_n = W1;
        end else begin
          state_n = IDLE;
        end
      end
      SERVE_VC1: begin
        if (pause) begin
          state_n = PAUSE;
          saved_n = SERVE_VC1;
        end else if (!VC1_empty) begin
          if (credit > 4'd1) begin
            credit_n = credit - 4'd1;
          end else if (!VC0_empty) begin
            state_n  = SERVE_VC0;
            credit_n = W0;
          end else begin
            credit_n = W1;
          end
        end else if (!VC0_empty) begin
          state_n  = SERVE_VC0;
          credit_n = W0;
        end else begin
          state_n = IDLE;
        end
      end
      PAUSE: begin
        if (!pause) state_n = saved;
      end
      default: state_n = IDLE;
    endcase
  end

  // Output mux select lags the pop by one cycle to match FIFO read latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vc0_delay <= 1'b0;
    end else if (VC1_pop) begin
      vc0_delay <= 1'b1;
    end else if (VC0_pop) begin
      vc0_delay <= 1'b0;
    end
  end

`ifdef VC_ARB_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vc0_grant_cnt <= 16'd0;
      vc1_grant_cnt <= 16'd0;
    end else if (stats_clr) begin
      vc0_grant_cnt <= 16'd0;
      vc1_grant_cnt <= 16'd0;
    end else begin
      if (VC0_pop && vc0_grant_cnt != 16'hFFFF)
        vc0_grant_cnt <= vc0_grant_cnt + 16'd1;
      if (VC1_pop && vc1_grant_cnt != 16'hFFFF)
        vc1_grant_cnt <= vc1_grant_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vc_arbiter.sv
// Directed scoreboard bench for vc_arbiter with FIFO occupancy models.
// Stats checks are compiled in when VC_ARB_STATS_EN is defined.
module tb_vc_arbiter;

  logic clk = 1'b0;
  logic reset;
  logic VC0_empty, VC1_empty, pause;
  logic VC0_pop, VC1_pop, vc0_delay, arb_idle;
`ifdef VC_ARB_STATS_EN
  logic        stats_clr;
  logic [15:0] vc0_grant_cnt, vc1_grant_cnt;
`endif

  vc_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .VC0_empty (VC0_empty),
    .VC1_empty (VC1_empty),
    .pause     (pause),
`ifdef VC_ARB_STATS_EN
    .stats_clr     (stats_clr),
    .vc0_grant_cnt (vc0_grant_cnt),
    .vc1_grant_cnt (vc1_grant_cnt),
`endif
    .VC0_pop   (VC0_pop),
    .VC1_pop   (VC1_pop),
    .vc0_delay (vc0_delay),
    .arb_idle  (arb_idle)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] pops;
    logic       dly;
    logic       idle;
  } exp_t;

  exp_t  sbq[$];
  int    total = 0;
  int    bad = 0;
  int    cnt0 = 0;
  int    cnt1 = 0;
  int    cyc = 0;
  string tag = "init";

  task automatic upd();
    VC0_empty = (cnt0 == 0);
    VC1_empty = (cnt1 == 0);
  endtask

  task automatic push(input int n, input logic [1:0] p,
                      input logic d, input logic i);
    exp_t e;
    e.pops = p;
    e.dly  = d;
    e.idle = i;
    for (int k = 0; k < n; k++) sbq.push_back(e);
  endtask

  task automatic cmp(input string nm, input logic [15:0] got,
                     input logic [15:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s.%s cyc=%0d: got %0h want %0h",
             tag, nm, cyc, got, want);
    end
  endtask

  task automatic chk();
    exp_t e;
    if (sbq.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s.sb_empty cyc=%0d: got 0 want 1", tag, cyc);
    end else begin
      e = sbq.pop_front();
      cmp("pops", {14'd0, VC1_pop, VC0_pop}, {14'd0, e.pops});
      cmp("delay", {15'd0, vc0_delay}, {15'd0, e.dly});
      cmp("idle", {15'd0, arb_idle}, {15'd0, e.idle});
      cmp("onehot", {15'd0, VC0_pop & VC1_pop}, 16'd0);
    end
    cyc++;
  endtask

  task automatic step();
    logic p0, p1;
    @(negedge clk);
    p0 = VC0_pop;
    p1 = VC1_pop;
    chk();
    @(posedge clk);
    #1;
    if (p0 && cnt0 > 0) cnt0--;
    if (p1 && cnt1 > 0) cnt1--;
    upd();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  initial begin
    reset = 1'b1;
    pause = 1'b0;
`ifdef VC_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    upd();
    repeat (2) @(posedge clk);
    #1;

    tag = "reset";
    cyc = 0;
    push(1, 2'b00, 1'b0, 1'b1);
    run(1);

    // both FIFOs hold 10 words: 4xVC0, 1xVC1 until VC0 drains
    tag = "rr";
    cyc = 0;
    reset = 1'b0;
    cnt0 = 10;
    cnt1 = 10;
    upd();
    push(1, 2'b00, 1'b0, 1'b1);
    push(4, 2'b01, 1'b0, 1'b0);
    push(1, 2'b10, 1'b0, 1'b0);
    push(1, 2'b01, 1'b1, 1'b0);
    push(3, 2'b01, 1'b0, 1'b0);
    push(1, 2'b10, 1'b0, 1'b0);
    push(1, 2'b01, 1'b1, 1'b0);
    push(1, 2'b01, 1'b0, 1'b0);
    push(1, 2'b00, 1'b0, 1'b0);
    push(1, 2'b10, 1'b0, 1'b0);
    push(7, 2'b10, 1'b1, 1'b0);
    push(1, 2'b00, 1'b1, 1'b0);
    push(1, 2'b00, 1'b1, 1'b1);
    run(24);

    tag = "vc1only";
    cyc = 0;
    cnt1 = 3;
    upd();
    push(1, 2'b00, 1'b1, 1'b1);
    push(3, 2'b10, 1'b1, 1'b0);
    push(1, 2'b00, 1'b1, 1'b0);
    push(1, 2'b00, 1'b1, 1'b1);
    run(6);

    tag = "pause";
    cyc = 0;
    cnt0 = 10;
    cnt1 = 10;
    upd();
    push(1, 2'b00, 1'b1, 1'b1);
    push(1, 2'b01, 1'b1, 1'b0);
    push(1, 2'b01, 1'b0, 1'b0);
    run(3);
    pause = 1'b1;
    push(5, 2'b00, 1'b0, 1'b0);
    run(5);
    pause = 1'b0;
    push(1, 2'b00, 1'b0, 1'b0);
    push(2, 2'b01, 1'b0, 1'b0);
    push(1, 2'b10, 1'b0, 1'b0);
    push(1, 2'b01, 1'b1, 1'b0);
    run(5);

    tag = "rst_mid";
    push(3, 2'b01, 1'b0, 1'b0);
    run(3);
    #1;
    push(1, 2'b10, 1'b0, 1'b0);
    chk();
    reset = 1'b1;
    #1;
    push(1, 2'b00, 1'b0, 1'b1);
    chk();
    @(posedge clk);
    #1;
    reset = 1'b0;
    cnt0 = 10;
    cnt1 = 10;
    upd();
    cyc = 0;
    push(1, 2'b00, 1'b0, 1'b1);
    push(4, 2'b01, 1'b0, 1'b0);
    push(1, 2'b10, 1'b0, 1'b0);
    push(1, 2'b01, 1'b1, 1'b0);
    run(7);

`ifdef VC_ARB_STATS_EN
    tag = "stats";
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    cnt0 = 70000;
    cnt1 = 0;
    upd();
    repeat (70001) @(posedge clk);
    #1;
    cmp("sat", vc0_grant_cnt, 16'hFFFF);
    cmp("vc1cnt", vc1_grant_cnt, 16'd0);
    stats_clr = 1'b1;
    @(negedge clk);
    cmp("pop_at_clr", {15'd0, VC0_pop}, 16'd1);
    @(posedge clk);
    #1;
    stats_clr = 1'b0;
    cmp("clr", vc0_grant_cnt, 16'd0);
`endif

    tag = "end";
    cmp("sb_left", sbq.size(), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vc_arbiter.md
VC_ARBITER -- requirements
Module: vc_arbiter

Interface
REQ-001 SHALL have parameter VC0_WEIGHT, default 4, meaning max consecutive VC0 pops per turn (4-bit, 1..15; 0 treated as 1).
REQ-002 SHALL have parameter VC1_WEIGHT, default 1, meaning max consecutive VC1 pops per turn (4-bit, 1..15; 0 treated as 1).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port VC0_empty  input  1  VC0 FIFO empty flag.
REQ-006 SHALL have port VC1_empty  input  1  VC1 FIFO empty flag.
REQ-007 SHALL have port pause  input  1  downstream almost-full; blocks all pops.
REQ-008 SHALL have port VC0_pop  output  1  read strobe to VC0 FIFO.
REQ-009 SHALL have port VC1_pop  output  1  read strobe to VC1 FIFO.
REQ-010 SHALL have port vc0_delay  output  1  registered selector to output mux; 1 selects VC1 data.
REQ-011 SHALL have port arb_idle  output  1  high while FSM in IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, SERVE_VC0, SERVE_VC1, PAUSE, plus 4-bit credit register and saved-return-state register.
REQ-013 SHALL assert at most one of VC0_pop/VC1_pop in any cycle.
REQ-014 SHALL drive VC0_pop = (state==SERVE_VC0) & !VC0_empty & !pause; VC1_pop likewise for SERVE_VC1; combinational, zero latency.
REQ-015 IDLE: pause or both empty -> stay; else !VC0_empty -> SERVE_VC0, credit=VC0_WEIGHT; else -> SERVE_VC1, credit=VC1_WEIGHT (VC0 wins simultaneous arrival).
REQ-016 SERVE_x with pause high -> PAUSE, save x, no pop, credit unchanged.
REQ-017 SERVE_x, pop with credit>1 -> stay, credit-1.
REQ-018 SERVE_x, pop with credit==1 -> other VC's SERVE state with its weight if that VC non-empty, else stay with credit reloaded to own weight.
REQ-019 SERVE_x with own FIFO empty (no pop) -> other VC's SERVE state with its weight if non-empty, else IDLE.
REQ-020 PAUSE: stay while pause high; on pause low -> saved state with retained credit; first pop one cycle after pause falls.
REQ-021 vc0_delay SHALL register 1 the cycle after a VC1 pop, 0 the cycle after a VC0 pop, and hold otherwise.
REQ-022 arb_idle SHALL be combinational (state==IDLE).

Reset
REQ-023 Reset assertion SHALL immediately force state=IDLE, credit=0, saved state=SERVE_VC0, vc0_delay=0, so VC0_pop=VC1_pop=0, arb_idle=1.
REQ-024 Reset mid-turn SHALL discard remaining credit; after release, arbitration restarts per REQ-015 on the first clock edge.

Configuration
REQ-025 Macro VC_ARB_STATS_EN defined SHALL add input stats_clr (1), outputs vc0_grant_cnt and vc1_grant_cnt (16 bits each).
REQ-026 With VC_ARB_STATS_EN, each counter SHALL increment on its pop, saturate at 16'hFFFF, clear synchronously on stats_clr (clear wins over increment), reset to 0.
REQ-027 Without VC_ARB_STATS_EN, those ports and counters SHALL be absent; all other behaviour identical.

Verification
REQ-028 Both FIFOs hold 10 words, pause=0, default weights -> pop pattern 4xVC0, 1xVC1, repeating; vc0_delay follows one cycle later.
REQ-029 Only VC1 holds 3 words -> IDLE, then 3 consecutive VC1_pop, then IDLE; arb_idle returns 1.
REQ-030 Pause raised after 2nd VC0 pop for 5 cycles -> no pops during pause; 2 remaining VC0 pops resume one cycle after fall, then VC1.
REQ-031 Reset asserted during SERVE_VC1 -> pops drop to 0 same cycle, vc0_delay=0; after release with both FIFOs non-empty, VC0 served first with full credit.
REQ-032 VC_ARB_STATS_EN defined, 70000 VC0 pops -> vc0_grant_cnt=16'hFFFF; stats_clr coincident with a pop -> 0.
